// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: front-end fetch stage.
// Owns the architectural PC and issues in-order instruction-memory requests
// using a valid/ready handshake. It buffers the returned instruction words for
// decode, and it restarts fetching when a control-transfer redirect arrives.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req_vld/rdy/addr          fetch request handshake and address
//   imem_resp_vld/data             in-order responses, never back-pressured
//   jal_vld/tgt                    redirect from D
//   jalr_vld/tgt, branch_vld/tgt   redirects from X (older, higher priority)
//   stall_in                       decode not consuming the head instruction
//   instr, pc, pc_plus4, vld       head of the fetch buffer
module fetch_pc_gen #(
  parameter int unsigned        N_BITS       = 32,
  parameter logic [N_BITS-1:0]  RESET_VECTOR = '0,
  parameter int unsigned        DEPTH        = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_vld,
  input  logic              imem_req_rdy,
  output logic [N_BITS-1:0] imem_req_addr,
  input  logic              imem_resp_vld,
  input  logic [31:0]       imem_resp_data,
  input  logic              jal_vld,
  input  logic [N_BITS-1:0] jal_tgt,
  input  logic              jalr_vld,
  input  logic [N_BITS-1:0] jalr_tgt,
  input  logic              branch_vld,
  input  logic [N_BITS-1:0] branch_tgt,
  input  logic              stall_in,
  output logic [31:0]       instr,
  output logic [N_BITS-1:0] pc,
  output logic [N_BITS-1:0] pc_plus4,
  output logic              vld
);

  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  // Control state
  logic [N_BITS-1:0] pc_q, pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     occ_q, occ_d;
  logic [AW-1:0]     pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [AW-1:0]     fb_wr_q, fb_wr_d, fb_rd_q, fb_rd_d;

  // Data storage (not reset)
  logic [N_BITS-1:0] pq_mem_q   [DEPTH];
  logic [31:0]       fb_instr_q [DEPTH];
  logic [N_BITS-1:0] fb_pc_q    [DEPTH];

  logic              redirect;
  logic [N_BITS-1:0] redir_tgt;
  logic              req_fire;
  logic              resp_drop;
  logic              resp_keep;
  logic              fb_push;
  logic              fb_pop;
  logic [CW-1:0]     live_cnt;
  logic [CW:0]       in_use;
  logic [N_BITS-1:0] resp_pc;

  function automatic logic [N_BITS-1:0] align_tgt(input logic [N_BITS-1:0] t);
    return t & ~N_BITS'(3);
  endfunction

  // X-stage redirects are older than D-stage ones, so they take priority
  always_comb begin
    redir_tgt = align_tgt(jal_tgt);
    if (jalr_vld) begin
      redir_tgt = align_tgt(jalr_tgt);
    end else if (branch_vld) begin
      redir_tgt = align_tgt(branch_tgt);
    end
  end

  assign redirect = jal_vld | jalr_vld | branch_vld;

  // Credit rule: every accepted request already owns a buffer slot, so responses
  // never need back-pressure and the buffer cannot overflow under stall.
  assign in_use        = {1'b0, outst_q} + {1'b0, occ_q};
  assign imem_req_vld  = !rst && !redirect && (in_use < CREDITS);
  assign imem_req_addr = pc_q;
  assign req_fire      = imem_req_vld && imem_req_rdy;

  assign resp_pc   = pq_mem_q[pq_rd_q];
  assign resp_drop = imem_resp_vld && (drop_q != '0);
  assign resp_keep = imem_resp_vld && (drop_q == '0);

  assign vld     = (occ_q != '0);
  // A squash overrides both the incoming response and the decode stall
  assign fb_push = resp_keep && !redirect;
  assign fb_pop  = vld && !stall_in && !redirect;

  // Requests still in flight that would be delivered
  assign live_cnt = outst_q - drop_q;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redir_tgt;
    end else if (req_fire) begin
      pc_d = pc_q + N_BITS'(4);
    end

    outst_d = outst_q + CW'(req_fire) - CW'(imem_resp_vld);

    // On a redirect every remaining in-flight fetch becomes a drop. A response
    // arriving in the same cycle is retired now, so it is not counted again.
    drop_d = drop_q;
    if (redirect) begin
      drop_d = drop_q + live_cnt - CW'(imem_resp_vld);
    end else if (resp_drop) begin
      drop_d = drop_q - CW'(1);
    end

    // The pc queue is never flushed: its entries pair with dropped responses
    pq_wr_d = pq_wr_q + AW'(req_fire);
    pq_rd_d = pq_rd_q + AW'(imem_resp_vld);

    fb_wr_d = fb_wr_q;
    fb_rd_d = fb_rd_q;
    occ_d   = occ_q;
    if (redirect) begin
      fb_rd_d = fb_wr_q;
      occ_d   = '0;
    end else begin
      fb_wr_d = fb_wr_q + AW'(fb_push);
      fb_rd_d = fb_rd_q + AW'(fb_pop);
      occ_d   = occ_q + CW'(fb_push) - CW'(fb_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      outst_q <= '0;
      drop_q  <= '0;
      occ_q   <= '0;
      pq_wr_q <= '0;
      pq_rd_q <= '0;
      fb_wr_q <= '0;
      fb_rd_q <= '0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      occ_q   <= occ_d;
      pq_wr_q <= pq_wr_d;
      pq_rd_q <= pq_rd_d;
      fb_wr_q <= fb_wr_d;
      fb_rd_q <= fb_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      pq_mem_q[pq_wr_q] <= pc_q;
    end
    if (fb_push) begin
      fb_instr_q[fb_wr_q] <= imem_resp_data;
      fb_pc_q[fb_wr_q]    <= resp_pc;
    end
  end

  assign instr    = fb_instr_q[fb_rd_q];
  assign pc       = fb_pc_q[fb_rd_q];
  assign pc_plus4 = pc + N_BITS'(4);

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ({1'b0, outst_q} <= CREDITS);
      assert (drop_q <= outst_q);
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen. Main instance uses the defaults (DEPTH=2,
// RESET_VECTOR=0). A second free-running instance uses DEPTH=4 and
// RESET_VECTOR=0xFFFF_FFFC to exercise PC wrap-around.
module tb_fetch_pc_gen;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        resp_vld = 1'b0;
  logic [31:0] resp_data = '0;
  logic        jal_vld = 1'b0, jalr_vld = 1'b0, branch_vld = 1'b0;
  logic [31:0] jal_tgt = '0, jalr_tgt = '0, branch_tgt = '0;
  logic        stall = 1'b0;
  logic        req_vld, vld;
  logic [31:0] req_addr, instr, pc, pc_plus4;

  logic        rdy1 = 1'b1;
  logic        resp_vld1 = 1'b0;
  logic [31:0] resp_data1 = '0;
  logic        req_vld1, vld1;
  logic [31:0] req_addr1, instr1, pc1, pc_plus4_1;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = '0;

  logic        mem_en = 1'b1;
  logic [31:0] mq[$];
  logic [31:0] mq1[$];
  int          n_req = 0;
  int          vecs = 0;
  int          miscmp = 0;

  fetch_pc_gen u_dut (
    .clk(clk), .rst(rst),
    .imem_req_vld(req_vld), .imem_req_rdy(rdy), .imem_req_addr(req_addr),
    .imem_resp_vld(resp_vld), .imem_resp_data(resp_data),
    .jal_vld(jal_vld), .jal_tgt(jal_tgt),
    .jalr_vld(jalr_vld), .jalr_tgt(jalr_tgt),
    .branch_vld(branch_vld), .branch_tgt(branch_tgt),
    .stall_in(stall),
    .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .vld(vld)
  );

  fetch_pc_gen #(.N_BITS(32), .RESET_VECTOR(32'hFFFF_FFFC), .DEPTH(4)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_vld(req_vld1), .imem_req_rdy(rdy1), .imem_req_addr(req_addr1),
    .imem_resp_vld(resp_vld1), .imem_resp_data(resp_data1),
    .jal_vld(zero1), .jal_tgt(zero32),
    .jalr_vld(zero1), .jalr_tgt(zero32),
    .branch_vld(zero1), .branch_tgt(zero32),
    .stall_in(zero1),
    .instr(instr1), .pc(pc1), .pc_plus4(pc_plus4_1), .vld(vld1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: capture handshakes, advance, then drive this cycle's responses.
  // Memory latency is one cycle; it is reset together with the core.
  task automatic tick();
    logic        hs, hs1, rs;
    logic [31:0] a, a1;
    #1;
    hs  = req_vld && rdy;
    a   = req_addr;
    hs1 = req_vld1 && rdy1;
    a1  = req_addr1;
    rs  = rst;
    if (hs) n_req++;
    @(posedge clk);
    #1;
    if (rs) begin
      mq.delete();
      mq1.delete();
    end else begin
      if (hs)  mq.push_back(a);
      if (hs1) mq1.push_back(a1);
    end
    if (mem_en && mq.size() != 0) begin
      resp_vld  = 1'b1;
      resp_data = mq.pop_front() ^ KEY;
    end else begin
      resp_vld  = 1'b0;
      resp_data = '0;
    end
    if (mq1.size() != 0) begin
      resp_vld1  = 1'b1;
      resp_data1 = mq1.pop_front() ^ KEY;
    end else begin
      resp_vld1  = 1'b0;
      resp_data1 = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_vld", {31'b0, vld}, 32'd0);
    chk("rst_req_vld", {31'b0, req_vld}, 32'd0);
    chk("rst_req_addr", req_addr, 32'h0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset then free-run
    do_reset();
    chk("wrap_rst_addr", req_addr1, 32'hFFFF_FFFC);
    chk("c1_req_vld", {31'b0, req_vld}, 32'd1);
    chk("c1_addr", req_addr, 32'h0);
    tick();
    chk("c2_addr", req_addr, 32'h4);
    chk("c2_vld", {31'b0, vld}, 32'd0);
    chk("wrap_c2_addr", req_addr1, 32'h0);
    tick();
    chk("c3_vld", {31'b0, vld}, 32'd1);
    chk("c3_pc", pc, 32'h0);
    chk("c3_pc_plus4", pc_plus4, 32'h4);
    chk("c3_instr", instr, 32'h0 ^ KEY);
    chk("c3_credit", {31'b0, req_vld}, 32'd0);
    chk("wrap_c3_addr", req_addr1, 32'h4);
    chk("wrap_c3_pc", pc1, 32'hFFFF_FFFC);
    chk("wrap_c3_pc_plus4", pc_plus4_1, 32'h0);
    chk("wrap_c3_instr", instr1, 32'hFFFF_FFFC ^ KEY);
    tick();
    chk("c4_pc", pc, 32'h4);
    chk("c4_addr", req_addr, 32'h8);
    chk("c4_req_vld", {31'b0, req_vld}, 32'd1);
    chk("wrap_c4_addr", req_addr1, 32'h8);
    chk("wrap_c4_pc", pc1, 32'h0);

    // Backpressure with DEPTH=2
    stall = 1'b1;
    do_reset();
    n_req = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("bp_req_count", n_req, 32'd2);
    chk("bp_req_vld", {31'b0, req_vld}, 32'd0);
    chk("bp_head_pc", pc, 32'h0);
    stall = 1'b0;
    #1;
    chk("bp_release_req_vld", {31'b0, req_vld}, 32'd0);
    tick();
    chk("bp_pop_pc", pc, 32'h4);
    chk("bp_next_req_vld", {31'b0, req_vld}, 32'd1);
    chk("bp_next_addr", req_addr, 32'h8);

    // jalr redirect with two fetches in flight
    mem_en = 1'b0;
    do_reset();
    tick();
    tick();
    chk("jalr_full", {31'b0, req_vld}, 32'd0);
    jalr_vld = 1'b1;
    jalr_tgt = 32'h103;
    #1;
    chk("jalr_noreq", {31'b0, req_vld}, 32'd0);
    mem_en = 1'b1;
    tick();
    jalr_vld = 1'b0;
    #1;
    chk("jalr_drop1_vld", {31'b0, vld}, 32'd0);
    tick();
    chk("jalr_drop2_vld", {31'b0, vld}, 32'd0);
    chk("jalr_req_vld", {31'b0, req_vld}, 32'd1);
    chk("jalr_addr", req_addr, 32'h100);
    tick();
    chk("jalr_wait_vld", {31'b0, vld}, 32'd0);
    chk("jalr_addr2", req_addr, 32'h104);
    tick();
    chk("jalr_first_vld", {31'b0, vld}, 32'd1);
    chk("jalr_first_pc", pc, 32'h100);
    chk("jalr_first_instr", instr, 32'h100 ^ KEY);

    // Simultaneous jal and branch: branch (X) wins
    jal_vld    = 1'b1;
    jal_tgt    = 32'h200;
    branch_vld = 1'b1;
    branch_tgt = 32'h300;
    #1;
    chk("jb_noreq", {31'b0, req_vld}, 32'd0);
    tick();
    jal_vld    = 1'b0;
    branch_vld = 1'b0;
    #1;
    chk("jb_flush", {31'b0, vld}, 32'd0);
    chk("jb_req_vld", {31'b0, req_vld}, 32'd1);
    chk("jb_addr", req_addr, 32'h300);
    tick();
    tick();
    chk("jb_vld", {31'b0, vld}, 32'd1);
    chk("jb_pc", pc, 32'h300);

    // Redirect coincident with a response, two outstanding
    mem_en = 1'b0;
    do_reset();
    tick();
    tick();
    mem_en = 1'b1;
    tick();
    branch_vld = 1'b1;
    branch_tgt = 32'h400;
    #1;
    chk("co_noreq", {31'b0, req_vld}, 32'd0);
    tick();
    branch_vld = 1'b0;
    #1;
    chk("co_addr", req_addr, 32'h400);
    chk("co_req_vld", {31'b0, req_vld}, 32'd1);
    chk("co_flush", {31'b0, vld}, 32'd0);
    tick();
    chk("co_drop", {31'b0, vld}, 32'd0);
    tick();
    chk("co_deliver_vld", {31'b0, vld}, 32'd1);
    chk("co_deliver_pc", pc, 32'h400);
    chk("co_deliver_instr", instr, 32'h400 ^ KEY);

    // Redirect while stalled: the squash overrides the stall
    stall   = 1'b1;
    jal_vld = 1'b1;
    jal_tgt = 32'h501;
    #1;
    chk("st_noreq", {31'b0, req_vld}, 32'd0);
    tick();
    jal_vld = 1'b0;
    #1;
    chk("st_flush", {31'b0, vld}, 32'd0);
    chk("st_addr", req_addr, 32'h500);
    chk("st_req_vld", {31'b0, req_vld}, 32'd1);
    tick();
    tick();
    chk("st_vld", {31'b0, vld}, 32'd1);
    chk("st_pc", pc, 32'h500);
    chk("st_pc_plus4", pc_plus4, 32'h504);
    stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
